alu_seq_unit: RTL and testbench



---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_mul_iter.sv | 51 +++++
 rtl/alu_seq_unit.sv | 161 ++++++++++++++++
 tb/tb_alu_seq_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode map, control states and the
// flag bundle that is loaded together with the result.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_LSL = 4'b0000,
      OP_LSR = 4'b0001,
      OP_ASR = 4'b0010,
      OP_NOT = 4'b0011,
      OP_AND = 4'b0100,
      OP_OR  = 4'b0101,
      OP_XOR = 4'b0110,
      OP_ADD = 4'b0111,
      OP_SUB = 4'b1000,
      OP_MUL = 4'b1001
   } alu_op_e;

   typedef enum logic {
      IDLE     = 1'b0,
      MUL_BUSY = 1'b1
   } alu_state_e;

   localparam alu_op_e OP_LAST_LEGAL = OP_MUL;

   typedef struct packed {
      logic cout;
      logic overflow;
      logic negative;
      logic zero;
      logic illegal;
   } alu_flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH steps.
// o_prod is the product including the step being taken this cycle.
module alu_mul_iter #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_start,
   input  logic [WIDTH-1:0]   i_a,
   input  logic [WIDTH-1:0]   i_b,
   output logic               o_done,
   output logic [2*WIDTH-1:0] o_prod
);

   localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(WIDTH - 1);

   logic                 r_busy;
   logic [WIDTH-1:0]     r_cnt;
   logic [2*WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]     r_mplier;
   logic [2*WIDTH-1:0]   r_prod;
   logic [2*WIDTH-1:0]   w_prod_nxt;

   assign w_prod_nxt = r_prod + (r_mplier[0] ? r_mcand : '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy   <= 1'b0;
         r_cnt    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_prod   <= '0;
      end else if (i_start) begin
         r_busy   <= 1'b1;
         r_cnt    <= '0;
         r_mcand  <= {{WIDTH{1'b0}}, i_a};
         r_mplier <= i_b;
         r_prod   <= '0;
      end else if (r_busy) begin
         r_prod   <= w_prod_nxt;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + WIDTH'(1);
         if (r_cnt == CNT_LAST) r_busy <= 1'b0;
      end
   end

   assign o_done = r_busy && (r_cnt == CNT_LAST);
   assign o_prod = w_prod_nxt;

endmodule

// File: rtl/alu_seq_unit.sv
// Registered, valid/ready ALU: single-cycle ops land in the output register on
// the accept edge; MUL runs in the iterative multiplier and lands WIDTH cycles later.
module alu_seq_unit
   import alu_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       opcode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             cout,
   output logic             overflow,
   output logic             negative,
   output logic             zero,
   output logic             illegal
);

   alu_state_e           r_state;
   alu_state_e           w_state_nxt;
   logic                 r_out_valid;
   logic [WIDTH-1:0]     r_y;
   alu_flags_t           r_flags;

   logic                 w_in_ready;
   logic                 w_accept;
   logic                 w_is_mul;
   logic                 w_mul_start;
   logic                 w_mul_done;
   logic                 w_load;
   logic [2*WIDTH-1:0]   w_mul_prod;

   logic [WIDTH:0]       w_lsl;
   logic [WIDTH:0]       w_lsr;
   logic [WIDTH:0]       w_asr;
   logic [WIDTH:0]       w_add;
   logic [WIDTH:0]       w_sub;
   logic [WIDTH-1:0]     w_op_y;
   logic                 w_op_cout;
   logic                 w_op_ovf;
   logic                 w_op_ill;
   logic [WIDTH-1:0]     w_ld_y;
   alu_flags_t           w_ld_flags;

   assign w_is_mul = MUL_EN && (opcode == OP_MUL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:     if (w_accept && w_is_mul) w_state_nxt = MUL_BUSY;
         MUL_BUSY: if (w_mul_done)           w_state_nxt = IDLE;
         default:  w_state_nxt = IDLE;
      endcase
   end

   // in_ready is gated by rst_n so nothing is offered while reset is held
   always_comb begin
      w_in_ready  = rst_n && (r_state == IDLE) && (!r_out_valid || out_ready);
      w_accept    = in_valid && w_in_ready;
      w_mul_start = w_accept && w_is_mul;
      w_load      = (w_accept && !w_is_mul) || ((r_state == MUL_BUSY) && w_mul_done);
   end

   alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_start (w_mul_start),
      .i_a     (a),
      .i_b     (b),
      .o_done  (w_mul_done),
      .o_prod  (w_mul_prod)
   );

   // One guard bit beside the operand: it catches the last bit shifted out,
   // and large shift amounts naturally flush to zero or to sign copies.
   assign w_lsl = {1'b0, a} << b;
   assign w_lsr = {a, 1'b0} >> b;
   assign w_asr = $signed({a, 1'b0}) >>> b;
   assign w_add = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
   assign w_sub = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

   always_comb begin
      w_op_y    = '0;
      w_op_cout = 1'b0;
      w_op_ovf  = 1'b0;
      w_op_ill  = (opcode > OP_LAST_LEGAL) || (!MUL_EN && (opcode == OP_MUL));
      case (opcode)
         OP_LSL: begin w_op_y = w_lsl[WIDTH-1:0]; w_op_cout = w_lsl[WIDTH]; end
         OP_LSR: begin w_op_y = w_lsr[WIDTH:1];   w_op_cout = w_lsr[0];     end
         OP_ASR: begin w_op_y = w_asr[WIDTH:1];   w_op_cout = w_asr[0];     end
         OP_NOT: w_op_y = ~a;
         OP_AND: w_op_y = a & b;
         OP_OR:  w_op_y = a | b;
         OP_XOR: w_op_y = a ^ b;
         OP_ADD: begin
            w_op_y    = w_add[WIDTH-1:0];
            w_op_cout = w_add[WIDTH];
            w_op_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            w_op_y    = w_sub[WIDTH-1:0];
            w_op_cout = w_sub[WIDTH];
            w_op_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);
         end
         default: ;
      endcase
   end

   always_comb begin
      w_ld_y              = w_op_y;
      w_ld_flags          = '0;
      w_ld_flags.cout     = w_op_cout;
      w_ld_flags.overflow = w_op_ovf;
      w_ld_flags.illegal  = w_op_ill;
      if (r_state == MUL_BUSY) begin
         w_ld_y              = w_mul_prod[WIDTH-1:0];
         w_ld_flags.cout     = |w_mul_prod[2*WIDTH-1:WIDTH];
         w_ld_flags.overflow = 1'b0;
         w_ld_flags.illegal  = 1'b0;
      end
      w_ld_flags.negative = w_ld_y[WIDTH-1];
      w_ld_flags.zero     = (w_ld_y == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_y         <= '0;
         r_flags     <= '0;
      end else if (w_load) begin
         r_out_valid <= 1'b1;
         r_y         <= w_ld_y;
         r_flags     <= w_ld_flags;
      end else if (r_out_valid && out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = r_out_valid;
   assign y         = r_y;
   assign cout      = r_flags.cout;
   assign overflow  = r_flags.overflow;
   assign negative  = r_flags.negative;
   assign zero      = r_flags.zero;
   assign illegal   = r_flags.illegal;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Random + directed bench for alu_seq_unit (WIDTH=4) against a transaction-level
// reference: results from plain arithmetic, timing from the handshake rules.
module tb_alu_seq_unit;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] opcode;
   logic [3:0] a;
   logic [3:0] b;
   logic       cin;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] y;
   logic       cout;
   logic       overflow;
   logic       negative;
   logic       zero;
   logic       illegal;

   int n_vec;
   int n_err;

   bit         m_valid;
   int         m_busy;
   logic [8:0] m_res;
   logic [8:0] m_pend;

   alu_seq_unit #(.WIDTH(4), .MUL_EN(1'b1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .opcode    (opcode),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .cout      (cout),
      .overflow  (overflow),
      .negative  (negative),
      .zero      (zero),
      .illegal   (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int sx(input logic [3:0] x);
      return (x > 4'd7) ? int'(x) - 16 : int'(x);
   endfunction

   // Reference result packed as {illegal, overflow, cout, negative, zero, y}
   function automatic logic [8:0] ref_op(input logic [3:0] op, input logic [3:0] xa,
                                         input logic [3:0] xb, input logic xc);
      int v, co, ov, ill, s, sa;
      logic [3:0] r;
      v = 0; co = 0; ov = 0; ill = 0;
      case (op)
         4'd0: begin v = int'(xa); for (int i = 0; i < int'(xb); i++) begin co = (v >> 3) & 1; v = (v << 1) & 15; end end
         4'd1: begin v = int'(xa); for (int i = 0; i < int'(xb); i++) begin co = v & 1; v = v >> 1; end end
         4'd2: begin v = int'(xa); for (int i = 0; i < int'(xb); i++) begin co = v & 1; v = (v >> 1) | (v & 8); end end
         4'd3: v = 15 - int'(xa);
         4'd4: v = int'(xa & xb);
         4'd5: v = int'(xa | xb);
         4'd6: v = int'(xa ^ xb);
         4'd7: begin
            s = int'(xa) + int'(xb) + int'(xc); v = s % 16; co = s / 16;
            sa = sx(xa) + sx(xb) + int'(xc); ov = (sa > 7 || sa < -8) ? 1 : 0;
         end
         4'd8: begin
            s = int'(xa) + (15 - int'(xb)) + 1; v = s % 16; co = s / 16;
            sa = sx(xa) - sx(xb); ov = (sa > 7 || sa < -8) ? 1 : 0;
         end
         4'd9: begin s = int'(xa) * int'(xb); v = s % 16; co = (s / 16 != 0) ? 1 : 0; end
         default: ill = 1;
      endcase
      r = 4'(v);
      return {ill[0], ov[0], co[0], r[3], (r == 4'd0), r};
   endfunction

   task automatic monitor();
      logic [8:0] got;
      bit erdy, acc, cons;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
            chk("rst_y", {28'd0, y}, 32'd0);
            m_valid = 1'b0;
            m_busy  = 0;
         end else begin
            erdy = (m_busy == 0) && (!m_valid || out_ready);
            chk("in_ready", {31'd0, in_ready}, {31'd0, erdy});
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            got = {illegal, overflow, cout, negative, zero, y};
            if (m_valid) chk("result", {23'd0, got}, {23'd0, m_res});
            acc  = in_valid && erdy;
            cons = m_valid && out_ready;
            if (m_busy > 0) begin
               m_busy--;
               if (m_busy == 0) begin m_valid = 1'b1; m_res = m_pend; end
            end else if (acc) begin
               if (opcode == 4'd9) begin
                  m_pend = ref_op(opcode, a, b, cin);
                  m_busy = 4;
                  if (cons) m_valid = 1'b0;
               end else begin
                  m_res   = ref_op(opcode, a, b, cin);
                  m_valid = 1'b1;
               end
            end else if (cons) begin
               m_valid = 1'b0;
            end
         end
      end
   endtask

   // Present one op with out_ready=1; k = edges after accept until out_valid,
   // nb = post-edge samples with in_ready low while waiting.
   task automatic run_op(input logic [3:0] op, input logic [3:0] xa, input logic [3:0] xb,
                         input logic xc, output int k, output int nb);
      opcode = op; a = xa; b = xb; cin = xc; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      chk("op_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      k = 0; nb = 0;
      while (!out_valid && k < 20) begin
         if (!in_ready) nb++;
         @(posedge clk); #1;
         k++;
      end
   endtask

   task automatic send(input logic [3:0] op, input logic [3:0] xa, input logic [3:0] xb, input logic xc);
      bit got;
      opcode = op; a = xa; b = xb; cin = xc; in_valid = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 50 && !got; k++) begin
         @(negedge clk);
         got = in_ready;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!got) chk("send_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected end before 200000");
      $fatal(1);
   end

   initial begin
      int k, nb;
      n_vec = 0; n_err = 0;
      m_valid = 1'b0; m_busy = 0; m_res = '0; m_pend = '0;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      opcode = '0; a = '0; b = '0; cin = 1'b0;
      fork monitor(); join_none
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      run_op(4'b0000, 4'b0001, 4'b0001, 1'b0, k, nb);
      chk("lsl_lat", k, 0);
      chk("lsl_y", {28'd0, y}, 32'b0010);
      chk("lsl_cout", {31'd0, cout}, 0);
      chk("lsl_zero", {31'd0, zero}, 0);
      run_op(4'b0010, 4'b1001, 4'b0001, 1'b0, k, nb);
      chk("asr1_y", {28'd0, y}, 32'b1100);
      chk("asr1_neg", {31'd0, negative}, 1);
      chk("asr1_cout", {31'd0, cout}, 1);
      run_op(4'b0010, 4'b1001, 4'b0101, 1'b0, k, nb);
      chk("asr5_y", {28'd0, y}, 32'b1111);
      run_op(4'b0111, 4'b0111, 4'b0001, 1'b0, k, nb);
      chk("add_y", {28'd0, y}, 32'b1000);
      chk("add_ovf", {31'd0, overflow}, 1);
      chk("add_neg", {31'd0, negative}, 1);
      chk("add_cout", {31'd0, cout}, 0);
      run_op(4'b1000, 4'b0011, 4'b0011, 1'b0, k, nb);
      chk("sub_y", {28'd0, y}, 0);
      chk("sub_zero", {31'd0, zero}, 1);
      chk("sub_cout", {31'd0, cout}, 1);
      run_op(4'b1001, 4'b0101, 4'b0011, 1'b0, k, nb);
      chk("mul_lat", k, 4);
      chk("mul_busy", nb, 4);
      chk("mul_y", {28'd0, y}, 32'b1111);
      chk("mul_cout", {31'd0, cout}, 0);
      run_op(4'b1001, 4'b1111, 4'b1111, 1'b0, k, nb);
      chk("mulff_y", {28'd0, y}, 32'b0001);
      chk("mulff_cout", {31'd0, cout}, 1);
      run_op(4'b1100, 4'b1010, 4'b0101, 1'b1, k, nb);
      chk("ill_lat", k, 0);
      chk("ill_flag", {31'd0, illegal}, 1);
      chk("ill_y", {28'd0, y}, 0);

      // backpressure: first result must hold while two more ops wait
      out_ready = 1'b1; in_valid = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b0;
      send(4'b0111, 4'b0001, 4'b0001, 1'b0);
      opcode = 4'b0110; a = 4'b0101; b = 4'b0011; cin = 1'b0; in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("bp_in_ready", {31'd0, in_ready}, 0);
         chk("bp_valid", {31'd0, out_valid}, 1);
         chk("bp_hold_y", {28'd0, y}, 32'b0010);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(4'b0110, 4'b0101, 4'b0011, 1'b0);
      chk("bp_y2", {28'd0, y}, 32'b0110);
      send(4'b0101, 4'b1000, 4'b0001, 1'b0);
      chk("bp_y3", {28'd0, y}, 32'b1001);

      // reset in the middle of a multiply
      run_op(4'b0000, 4'b0001, 4'b0001, 1'b0, k, nb);
      opcode = 4'b1001; a = 4'b0011; b = 4'b0011; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("rstmul_valid", {31'd0, out_valid}, 0);
      chk("rstmul_y", {28'd0, y}, 0);
      chk("rstmul_rdy", {31'd0, in_ready}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_op(4'b0111, 4'b0010, 4'b0011, 1'b1, k, nb);
      chk("post_rst_lat", k, 0);
      chk("post_rst_y", {28'd0, y}, 32'b0110);

      for (int i = 0; i < 600; i++) begin
         in_valid = ($urandom % 4) != 0;
         opcode   = (($urandom % 4) == 0) ? 4'd9 : 4'($urandom % 16);
         a        = 4'($urandom);
         b        = (($urandom % 2) != 0) ? 4'($urandom % 6) : 4'($urandom);
         cin      = 1'($urandom);
         if (((i / 50) % 3) == 1) out_ready = (($urandom % 4) == 0);
         else                     out_ready = (($urandom % 4) != 0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      chk("drained", {31'd0, out_valid}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
